ctr_block_packer: RTL and testbench
===================================

CTR_BLOCK_PACKER -- requirements
Module: ctr_block_packer

Interface
REQ-001 SHALL have parameter keylen, default 128, meaning the block width presented to the CTR core.
REQ-002 SHALL have parameter wordlen, default 32, meaning the input word width; keylen SHALL be an integer multiple of wordlen (4 words per block at defaults).
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  meaning the asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  meaning load counter_base, clear state and enter FILL.
REQ-006 SHALL have port counter_base  input  keylen/2  meaning the initial block counter.
REQ-007 SHALL have port word_in  input  wordlen  meaning the message/cipher word.
REQ-008 SHALL have ports word_valid  input  1  and word_ready  output  1, forming the input handshake.
REQ-009 SHALL have port word_last  input  1  meaning word_in is the final word of the stream.
REQ-010 SHALL have port blk_out  output  keylen  meaning the packed block.
REQ-011 SHALL have ports blk_valid  output  1  and blk_ready  input  1, forming the output handshake.
REQ-012 SHALL have port blk_last  output  1  meaning blk_out is the final block.
REQ-013 SHALL have port blk_bytes  output  5  meaning the number of valid bytes in blk_out (4..16).
REQ-014 SHALL have port busy  output  1  meaning the FSM is not in IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, FILL and HOLD; a word transfers on word_valid & word_ready, and a block transfers on blk_valid & blk_ready.
REQ-016 SHALL drive word_ready=1 only in FILL; blk_valid=1 only in HOLD.
REQ-017 SHALL pack MSB-first: the first word of a block lands in blk_out[keylen-1 -: wordlen] and later words fill successively lower slots.
REQ-018 SHALL enter HOLD on the cycle after the 4th word transfers or a word with word_last transfers; block latency is 1 cycle.
REQ-019 SHALL zero unfilled word slots of a partial block and set blk_bytes = 4 x words accepted (16 for a full block).
REQ-020 SHALL set blk_last=1 in HOLD only when the block was closed by word_last.
REQ-021 SHALL hold blk_out, blk_bytes and blk_last stable while blk_valid=1 and blk_ready=0.
REQ-022 SHALL, on block transfer, increment the internal counter (mod 2^(keylen/2), so all-ones wraps to 0) and go to IDLE if blk_last, else FILL with word index 0.
REQ-023 SHALL ignore start=0 in IDLE; start=1 in any state SHALL load counter_base, clear the word index and partial data, drop blk_valid and enter FILL the next cycle, with start taking priority over any handshake in the same cycle.
REQ-024 SHALL discard word_valid while word_ready=0; no word is lost or duplicated across HOLD.

Reset
REQ-025 SHALL, while rst=0, asynchronously force IDLE, word_ready=0, blk_valid=0, blk_last=0, blk_bytes=0, blk_out=0, busy=0, counter=0, word index=0.
REQ-026 SHALL resume operation on the first posedge after rst deasserts; rst asserted mid-block SHALL discard that block.

Configuration
REQ-027 SHALL, when CTR_PACKER_COUNTER_OUT_EN is defined, add output blk_counter (keylen/2 bits) equal to the counter value bound to the current block, stable throughout HOLD and 0 in reset.
REQ-028 SHALL, when CTR_PACKER_COUNTER_OUT_EN is undefined, omit the blk_counter port; the internal counter still advances, and all other behaviour is identical.

Verification
REQ-029 SHALL cover: start with counter_base=0x10, then 4 words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF with last on the 4th -> blk_out=0x00112233_44556677_8899AABB_CCDDEEFF, blk_bytes=16, blk_last=1, blk_counter=0x10.
REQ-030 SHALL cover: 6 words with last on the 6th -> 1st block has blk_bytes=16 and blk_last=0; 2nd block has words 5-6 in the top slots, low 64 bits zero, blk_bytes=8, blk_last=1, counter 0x10 then 0x11.
REQ-031 SHALL cover: blk_ready held 0 for 10 cycles in HOLD with word_valid=1 -> blk_out stable, word_ready=0, no word consumed.
REQ-032 SHALL cover: counter_base=0xFFFF_FFFF_FFFF_FFFF with 2 full blocks -> blk_counter reads all-ones, then 0.
REQ-033 SHALL cover: start pulsed after 2 words, then 4 words -> one block containing only the 4 new words.
REQ-034 SHALL cover: rst pulsed low mid-HOLD, asynchronously between clock edges -> blk_valid=0 and busy=0 immediately, IDLE after release.

Source files
------------

// File: rtl/ctr_block_packer.sv
// ctr_block_packer: packs a stream of input words MSB-first into keylen-bit
// blocks for a CTR-mode core, tagging each block with a running block counter.
// Optional feature: define CTR_PACKER_COUNTER_OUT_EN to expose the counter
// bound to the presented block on output port blk_counter.
module ctr_block_packer #(
    parameter int unsigned keylen  = 128,
    parameter int unsigned wordlen = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [keylen/2-1:0]   counter_base,
    input  logic [wordlen-1:0]    word_in,
    input  logic                  word_valid,
    output logic                  word_ready,
    input  logic                  word_last,
    output logic [keylen-1:0]     blk_out,
    output logic                  blk_valid,
    input  logic                  blk_ready,
    output logic                  blk_last,
    output logic [4:0]            blk_bytes,
    output logic                  busy
`ifdef CTR_PACKER_COUNTER_OUT_EN
    ,
    output logic [keylen/2-1:0]   blk_counter
`endif
);

    localparam int unsigned WORDS          = keylen / wordlen;
    localparam int unsigned CTR_W          = keylen / 2;
    localparam int unsigned IDX_W          = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned BYTES_PER_WORD = wordlen / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [keylen-1:0]  data_q, data_d;
    logic [CTR_W-1:0]   cnt_q, cnt_d;
    logic [keylen-1:0]  blk_out_d;
    logic [4:0]         blk_bytes_d;
    logic               blk_last_d;
    logic [keylen-1:0]  merged;
    logic               word_xfer;
    logic               blk_xfer;

    // State and registered outputs; handshake flags decode the next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            data_q     <= '0;
            cnt_q      <= '0;
            blk_out    <= '0;
            blk_bytes  <= '0;
            blk_last   <= 1'b0;
            word_ready <= 1'b0;
            blk_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            blk_out    <= blk_out_d;
            blk_bytes  <= blk_bytes_d;
            blk_last   <= blk_last_d;
            word_ready <= (state_d == FILL);
            blk_valid  <= (state_d == HOLD);
            busy       <= (state_d != IDLE);
        end
    end

    // Next-state, packing and counter logic; start overrides any handshake
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        blk_out_d   = blk_out;
        blk_bytes_d = blk_bytes;
        blk_last_d  = blk_last;
        word_xfer   = word_valid & word_ready;
        blk_xfer    = blk_valid & blk_ready;

        // Partial block with the incoming word dropped into the current slot
        merged = data_q;
        for (int unsigned i = 0; i < WORDS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                merged[keylen-1-i*wordlen -: wordlen] = word_in;
            end
        end

        if (start) begin
            state_d    = FILL;
            idx_d      = '0;
            data_d     = '0;
            cnt_d      = counter_base;
            blk_last_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                end
                FILL: begin
                    if (word_xfer) begin
                        if (word_last || (idx_q == IDX_W'(WORDS - 1))) begin
                            state_d     = HOLD;
                            blk_out_d   = merged;
                            blk_bytes_d = 5'((32'(idx_q) + 32'd1) * BYTES_PER_WORD);
                            blk_last_d  = word_last;
                            idx_d       = '0;
                            data_d      = '0;
                        end else begin
                            idx_d  = idx_q + IDX_W'(1);
                            data_d = merged;
                        end
                    end
                end
                HOLD: begin
                    if (blk_xfer) begin
                        cnt_d      = cnt_q + CTR_W'(1);
                        blk_last_d = 1'b0;
                        idx_d      = '0;
                        state_d    = blk_last ? IDLE : FILL;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

`ifdef CTR_PACKER_COUNTER_OUT_EN
    // Counter bound to the block; only changes on block transfer or start
    assign blk_counter = cnt_q;
`endif

endmodule

// File: tb/tb_ctr_block_packer.sv
// Directed self-checking bench for ctr_block_packer (default parameters).
module tb_ctr_block_packer;

    logic         clk;
    logic         rst;
    logic         start;
    logic [63:0]  counter_base;
    logic [31:0]  word_in;
    logic         word_valid;
    logic         word_ready;
    logic         word_last;
    logic [127:0] blk_out;
    logic         blk_valid;
    logic         blk_ready;
    logic         blk_last;
    logic [4:0]   blk_bytes;
    logic         busy;
`ifdef CTR_PACKER_COUNTER_OUT_EN
    logic [63:0]  blk_counter;
`endif

    int checks = 0;
    int errors = 0;

    ctr_block_packer dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .counter_base (counter_base),
        .word_in      (word_in),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .word_last    (word_last),
        .blk_out      (blk_out),
        .blk_valid    (blk_valid),
        .blk_ready    (blk_ready),
        .blk_last     (blk_last),
        .blk_bytes    (blk_bytes),
        .busy         (busy)
`ifdef CTR_PACKER_COUNTER_OUT_EN
        ,
        .blk_counter  (blk_counter)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_ctr(input string tag, input logic [63:0] exp);
`ifdef CTR_PACKER_COUNTER_OUT_EN
        check(tag, 128'(blk_counter), 128'(exp));
`else
        if (exp === 64'hx) $display("unreachable %s", tag);
`endif
    endtask

    // Offer one word and wait (bounded) for it to be accepted
    task automatic push(input logic [31:0] w, input logic last);
        int n = 0;
        word_in    = w;
        word_last  = last;
        word_valid = 1'b1;
        while (!word_ready && n < 20) begin
            tick();
            n++;
        end
        check("push_ready", 128'(word_ready), 128'(1'b1));
        tick();
        word_valid = 1'b0;
        word_last  = 1'b0;
    endtask

    task automatic do_start(input logic [63:0] base);
        counter_base = base;
        start        = 1'b1;
        tick();
        start        = 1'b0;
    endtask

    task automatic release_blk();
        blk_ready = 1'b1;
        tick();
        blk_ready = 1'b0;
    endtask

    initial begin
        logic [127:0] held;
        rst          = 1'b0;
        start        = 1'b0;
        counter_base = '0;
        word_in      = '0;
        word_valid   = 1'b0;
        word_last    = 1'b0;
        blk_ready    = 1'b0;
        #2;

        // Reset state
        check("rst_word_ready", 128'(word_ready), 128'(0));
        check("rst_blk_valid",  128'(blk_valid),  128'(0));
        check("rst_blk_last",   128'(blk_last),   128'(0));
        check("rst_blk_bytes",  128'(blk_bytes),  128'(0));
        check("rst_blk_out",    blk_out,          128'(0));
        check("rst_busy",       128'(busy),       128'(0));
        check_ctr("rst_counter", 64'h0);

        tick();
        rst = 1'b1;
        tick();

        // IDLE ignores words and start=0
        word_valid = 1'b1;
        word_in    = 32'hABCD0123;
        tick();
        tick();
        check("idle_busy",  128'(busy),       128'(0));
        check("idle_ready", 128'(word_ready), 128'(0));
        word_valid = 1'b0;

        // Single full block closed by word_last
        do_start(64'h10);
        check("start_busy",  128'(busy),       128'(1));
        check("start_ready", 128'(word_ready), 128'(1));
        push(32'h00112233, 1'b0);
        push(32'h44556677, 1'b0);
        push(32'h8899AABB, 1'b0);
        push(32'hCCDDEEFF, 1'b1);
        check("b1_valid", 128'(blk_valid), 128'(1));
        check("b1_out",   blk_out, 128'h00112233_44556677_8899AABB_CCDDEEFF);
        check("b1_bytes", 128'(blk_bytes), 128'(16));
        check("b1_last",  128'(blk_last),  128'(1));
        check("b1_ready", 128'(word_ready), 128'(0));
        check_ctr("b1_ctr", 64'h10);
        release_blk();
        check("b1_done_valid", 128'(blk_valid), 128'(0));
        check("b1_done_busy",  128'(busy),      128'(0));

        // Six words: full block then partial block, with backpressure
        do_start(64'h10);
        push(32'h11111111, 1'b0);
        push(32'h22222222, 1'b0);
        push(32'h33333333, 1'b0);
        push(32'h44444444, 1'b0);
        check("b2_out",   blk_out, 128'h11111111_22222222_33333333_44444444);
        check("b2_bytes", 128'(blk_bytes), 128'(16));
        check("b2_last",  128'(blk_last),  128'(0));
        check_ctr("b2_ctr", 64'h10);
        held       = blk_out;
        word_in    = 32'h55555555;
        word_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_out",   blk_out, held);
            check("bp_ready", 128'(word_ready), 128'(0));
            check("bp_valid", 128'(blk_valid),  128'(1));
        end
        release_blk();
        check("b2_after_ready", 128'(word_ready), 128'(1));
        push(32'h55555555, 1'b0);
        push(32'h66666666, 1'b1);
        check("b3_out",   blk_out, 128'h55555555_66666666_00000000_00000000);
        check("b3_bytes", 128'(blk_bytes), 128'(8));
        check("b3_last",  128'(blk_last),  128'(1));
        check_ctr("b3_ctr", 64'h11);
        release_blk();
        check("b3_done_busy", 128'(busy), 128'(0));

        // Counter wrap from all-ones
        do_start(64'hFFFF_FFFF_FFFF_FFFF);
        push(32'h01010101, 1'b0);
        push(32'h02020202, 1'b0);
        push(32'h03030303, 1'b0);
        push(32'h04040404, 1'b0);
        check_ctr("wrap_ctr0", 64'hFFFF_FFFF_FFFF_FFFF);
        check("wrap_last0", 128'(blk_last), 128'(0));
        release_blk();
        push(32'h05050505, 1'b0);
        push(32'h06060606, 1'b0);
        push(32'h07070707, 1'b0);
        push(32'h08080808, 1'b1);
        check_ctr("wrap_ctr1", 64'h0);
        check("wrap_out1", blk_out, 128'h05050505_06060606_07070707_08080808);
        release_blk();

        // Restart mid-fill discards the partial words
        do_start(64'h20);
        push(32'hAAAA0001, 1'b0);
        push(32'hAAAA0002, 1'b0);
        do_start(64'h21);
        push(32'hBBBB0001, 1'b0);
        push(32'hBBBB0002, 1'b0);
        push(32'hBBBB0003, 1'b0);
        push(32'hBBBB0004, 1'b1);
        check("rs_out",   blk_out, 128'hBBBB0001_BBBB0002_BBBB0003_BBBB0004);
        check("rs_bytes", 128'(blk_bytes), 128'(16));
        check_ctr("rs_ctr", 64'h21);

        // start beats a simultaneous block handshake
        counter_base = 64'h30;
        start        = 1'b1;
        blk_ready    = 1'b1;
        tick();
        start        = 1'b0;
        blk_ready    = 1'b0;
        check("pri_valid", 128'(blk_valid),  128'(0));
        check("pri_ready", 128'(word_ready), 128'(1));
        check("pri_last",  128'(blk_last),   128'(0));
        check_ctr("pri_ctr", 64'h30);

        // Single-word partial block
        push(32'hDEADBEEF, 1'b1);
        check("one_out",   blk_out, 128'hDEADBEEF_00000000_00000000_00000000);
        check("one_bytes", 128'(blk_bytes), 128'(4));
        check("one_last",  128'(blk_last),  128'(1));

        // Asynchronous reset mid-HOLD, between clock edges
        #2;
        rst = 1'b0;
        #1;
        check("arst_valid", 128'(blk_valid),  128'(0));
        check("arst_busy",  128'(busy),       128'(0));
        check("arst_ready", 128'(word_ready), 128'(0));
        check("arst_out",   blk_out,          128'(0));
        check("arst_bytes", 128'(blk_bytes),  128'(0));
        check("arst_last",  128'(blk_last),   128'(0));
        check_ctr("arst_ctr", 64'h0);
        tick();
        rst = 1'b1;
        tick();
        check("post_rst_busy",  128'(busy),      128'(0));
        check("post_rst_valid", 128'(blk_valid), 128'(0));

        // Normal operation resumes after reset
        do_start(64'h40);
        push(32'hC0C0C0C0, 1'b0);
        push(32'hC1C1C1C1, 1'b0);
        push(32'hC2C2C2C2, 1'b0);
        push(32'hC3C3C3C3, 1'b1);
        check("resume_out", blk_out, 128'hC0C0C0C0_C1C1C1C1_C2C2C2C2_C3C3C3C3);
        check_ctr("resume_ctr", 64'h40);
        release_blk();
        check("resume_busy", 128'(busy), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
